breakout_session_controller: RTL and testbench
==============================================

Name: breakout_session_controller

Overview:
- Top-level game-flow sequencer for the breakout game logic.
- Issues the once-per-frame START_UPDATE that launches the 12-substep physics run, and gates the serve button.
- Tracks lives, level and a 4-digit BCD score.
- Sequences serve, ball-lost, level-clear and game-over phases.
- Sits between VGA frame timing, the buttons, the game logic and the display overlay.

Parameters:
- START_LIVES, 3, lives loaded at new game (1..7).
- LOST_DELAY_FRAMES, 60, frozen frames after ball loss.
- CLEAR_DELAY_FRAMES, 90, frozen frames after level cleared.
- MAX_LEVEL, 7, highest level; clearing it wraps LEVEL to 0.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- FRAME_TICK  in  1  one-cycle pulse at frame start.
- BTN_START  in  1  level, debounced; starts a game.
- BTN_RELEASE  in  1  level, debounced; serve request.
- BALL_LOST  in  1  one-cycle pulse from game logic: ball passed below the paddle.
- BLOCK_HIT  in  1  one-cycle pulse per destroyed block.
- ALL_CLEARED  in  1  level; block state is all zero.
- START_UPDATE  out  1  one-cycle pulse, launches a frame of physics.
- RELEASE_OUT  out  1  BTN_RELEASE gated by SERVE state.
- BALL_RESET  out  1  one-cycle pulse: ball back to paddle, velocity zero.
- BLOCKS_RELOAD  out  1  one-cycle pulse: refill block state.
- LIVES  out  3  remaining lives.
- LEVEL  out  3  current level (speed selector for logic).
- SCORE_BCD  out  16  four BCD digits.
- PHASE  out  3  current state encoding, for the overlay.

Behaviour:
- Reset values: state IDLE, LIVES=0, LEVEL=0, SCORE_BCD=0, all pulses 0, delay counter 0.
- IDLE (0): no START_UPDATE. BTN_START high moves to SERVE and, in the same transition:
  - LIVES←START_LIVES, LEVEL←0, SCORE←0;
  - pulse BLOCKS_RELOAD and BALL_RESET for 1 cycle.
- SERVE (1):
  - START_UPDATE pulses the cycle after each FRAME_TICK, so the paddle moves.
  - RELEASE_OUT=BTN_RELEASE.
  - BTN_RELEASE high moves to PLAY.
- PLAY (2):
  - START_UPDATE per FRAME_TICK, RELEASE_OUT=0.
  - ALL_CLEARED high → CLEAR.
  - Else BALL_LOST → LOST.
- LOST (3):
  - LIVES decremented on entry; START_UPDATE suppressed.
  - Delay counter loaded with LOST_DELAY_FRAMES and decremented per FRAME_TICK.
  - At 0: if LIVES==0 go to OVER; else pulse BALL_RESET and go to SERVE.
- CLEAR (4):
  - Same delay mechanism with CLEAR_DELAY_FRAMES.
  - At 0: LEVEL←LEVEL+1, wrapping to 0 after MAX_LEVEL.
  - Pulse BLOCKS_RELOAD and BALL_RESET, then go to SERVE.
- OVER (5): frozen. BTN_START behaves as in IDLE, but only after BTN_START has been seen low once (edge-qualified, so a held button does not restart).
- START_UPDATE latency: exactly 1 cycle after FRAME_TICK; never more than one per frame; never asserted in IDLE, LOST, CLEAR or OVER.
- Score:
  - +1 BCD per BLOCK_HIT in any state.
  - Carries ripple combinationally within the same cycle.
  - Saturates at 9999 (no wrap).
- Simultaneous events:
  - ALL_CLEARED and BALL_LOST in the same cycle: CLEAR wins, no life lost.
  - BLOCK_HIT in the same cycle as BALL_LOST: still scored.
  - BALL_LOST outside PLAY: ignored.
  - FRAME_TICK on the cycle of a transition into SERVE: ignored (first update follows the next tick).
- Delay counter width: enough bits for max(LOST_DELAY_FRAMES, CLEAR_DELAY_FRAMES); a parameter of 0 means exit on the first FRAME_TICK.
- RESET mid-operation: returns to reset values next edge; any in-progress pulse is dropped.

Optional Feature:
- Macro: BREAKOUT_PAUSE_EN.
- When defined:
  - Adds input BTN_PAUSE and PHASE value PAUSED (6).
  - A rising edge of BTN_PAUSE in SERVE or PLAY enters PAUSED and remembers the return state.
  - In PAUSED: no START_UPDATE, BALL_LOST and BLOCK_HIT are ignored.
  - The next rising edge returns to the remembered state.
- When undefined: no port, no state; PHASE never equals 6.

Decomposition:
- Shared package `breakout_pkg`:
  - phase encodings IDLE..PAUSED;
  - START_LIVES default;
  - BCD digit width;
  - MAX_SCORE_BCD = 16'h9999.
- One natural sub-module: `bcd_score_counter` (4-digit saturating BCD incrementer with synchronous clear, 1-cycle registered output).

Test Plan:
- RESET then BTN_START → BLOCKS_RELOAD and BALL_RESET pulse once; LIVES=3; PHASE=1; START_UPDATE 1 cycle after each FRAME_TICK, never in IDLE.
- Serve, then BALL_LOST in PLAY → LIVES=2, PHASE=3. No START_UPDATE for 60 FRAME_TICKs, then BALL_RESET pulse and PHASE=1.
- Three losses → PHASE=5, LIVES=0. Holding BTN_START through the transition does not restart; release then press → new game.
- ALL_CLEARED and BALL_LOST in the same cycle → PHASE=4, LIVES unchanged. After 90 ticks LEVEL=1 and BLOCKS_RELOAD pulses. At LEVEL=7 a clear yields LEVEL=0.
- SCORE preloaded via 9998 hits → 9999 on the next hit; a further hit stays at 9999. A hit at 0099 → 0100.
- With BREAKOUT_PAUSE_EN: pause in PLAY → no START_UPDATE and BALL_LOST ignored; second press → PHASE=2, updates resume on the next tick.

Source files
------------

// File: rtl/breakout_session_controller_pkg.sv
// Shared definitions for the breakout game-flow controller: phase encodings,
// score geometry and pulse bundle. BREAKOUT_PAUSE_EN enables the PAUSED phase.
package breakout_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SERVE  = 3'd1,
        PH_PLAY   = 3'd2,
        PH_LOST   = 3'd3,
        PH_CLEAR  = 3'd4,
        PH_OVER   = 3'd5,
        PH_PAUSED = 3'd6
    } phase_e;

    localparam int          START_LIVES_DEF = 3;
    localparam int          BCD_DIGIT_W     = 4;
    localparam int          BCD_DIGITS      = 4;
    localparam int          SCORE_W         = BCD_DIGIT_W * BCD_DIGITS;
    localparam logic [15:0] MAX_SCORE_BCD   = 16'h9999;

    typedef struct packed {
        logic start_update;
        logic ball_reset;
        logic blocks_reload;
    } pulse_t;

    // Counter width able to hold the larger of the two freeze delays.
    function automatic int cnt_width(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/breakout_session_controller_if.sv
// Game-flow bus between the session controller and frame timing, buttons,
// game logic and overlay. BTN_PAUSE exists only with BREAKOUT_PAUSE_EN.
interface breakout_session_controller_if;

    logic        FRAME_TICK;
    logic        BTN_START;
    logic        BTN_RELEASE;
    logic        BALL_LOST;
    logic        BLOCK_HIT;
    logic        ALL_CLEARED;
`ifdef BREAKOUT_PAUSE_EN
    logic        BTN_PAUSE;
`endif
    logic        START_UPDATE;
    logic        RELEASE_OUT;
    logic        BALL_RESET;
    logic        BLOCKS_RELOAD;
    logic [2:0]  LIVES;
    logic [2:0]  LEVEL;
    logic [15:0] SCORE_BCD;
    logic [2:0]  PHASE;

`ifdef BREAKOUT_PAUSE_EN
    modport slave (
        input  FRAME_TICK, BTN_START, BTN_RELEASE, BALL_LOST, BLOCK_HIT, ALL_CLEARED, BTN_PAUSE,
        output START_UPDATE, RELEASE_OUT, BALL_RESET, BLOCKS_RELOAD, LIVES, LEVEL, SCORE_BCD, PHASE
    );
    modport master (
        output FRAME_TICK, BTN_START, BTN_RELEASE, BALL_LOST, BLOCK_HIT, ALL_CLEARED, BTN_PAUSE,
        input  START_UPDATE, RELEASE_OUT, BALL_RESET, BLOCKS_RELOAD, LIVES, LEVEL, SCORE_BCD, PHASE
    );
`else
    modport slave (
        input  FRAME_TICK, BTN_START, BTN_RELEASE, BALL_LOST, BLOCK_HIT, ALL_CLEARED,
        output START_UPDATE, RELEASE_OUT, BALL_RESET, BLOCKS_RELOAD, LIVES, LEVEL, SCORE_BCD, PHASE
    );
    modport master (
        output FRAME_TICK, BTN_START, BTN_RELEASE, BALL_LOST, BLOCK_HIT, ALL_CLEARED,
        input  START_UPDATE, RELEASE_OUT, BALL_RESET, BLOCKS_RELOAD, LIVES, LEVEL, SCORE_BCD, PHASE
    );
`endif

endinterface

// File: rtl/breakout_session_controller_bcd.sv
// Four-digit saturating BCD score counter: synchronous clear, +1 per inc,
// carries ripple within the cycle, registered output.
module bcd_score_counter
    import breakout_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score_bcd
);

    logic [SCORE_W-1:0]     score_q, score_d;
    logic [BCD_DIGIT_W-1:0] dig;
    logic                   carry;

    always_comb begin
        score_d = score_q;
        dig     = '0;
        carry   = 1'b0;
        if (clr) begin
            score_d = '0;
        end else if (inc && (score_q != MAX_SCORE_BCD)) begin
            carry = 1'b1;
            for (int i = 0; i < BCD_DIGITS; i++) begin
                dig = score_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                if (carry) begin
                    if (dig == BCD_DIGIT_W'(9)) begin
                        dig = '0;
                    end else begin
                        dig   = dig + BCD_DIGIT_W'(1);
                        carry = 1'b0;
                    end
                end
                score_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) score_q <= '0;
        else     score_q <= score_d;
    end

    assign score_bcd = score_q;

endmodule

// File: rtl/breakout_session_controller.sv
// Breakout game-flow sequencer: frame update launch, serve gating, lives,
// level and score. BREAKOUT_PAUSE_EN adds BTN_PAUSE and the PAUSED phase.
module breakout_session_controller
    import breakout_pkg::*;
#(
    parameter int START_LIVES        = START_LIVES_DEF,
    parameter int LOST_DELAY_FRAMES  = 60,
    parameter int CLEAR_DELAY_FRAMES = 90,
    parameter int MAX_LEVEL          = 7
) (
    input  logic CLK,
    input  logic RESET,
    breakout_session_controller_if.slave bus
);

    localparam int CNT_W = cnt_width(LOST_DELAY_FRAMES, CLEAR_DELAY_FRAMES);

    phase_e             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pulse_t             pulse_q, pulse_d;
    logic               armed_q, armed_d;
    logic               score_clr, score_inc;
    logic               delay_done;
    logic               pause_rise;
`ifdef BREAKOUT_PAUSE_EN
    logic               btn_pause_q;
    phase_e             ret_q, ret_d;
    assign pause_rise = bus.BTN_PAUSE & ~btn_pause_q;
`else
    assign pause_rise = 1'b0;
`endif

    function automatic logic is_active(phase_e p);
        return (p == PH_SERVE) || (p == PH_PLAY);
    endfunction

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        pulse_d    = '0;
        score_clr  = 1'b0;
        score_inc  = bus.BLOCK_HIT;
`ifdef BREAKOUT_PAUSE_EN
        ret_d      = ret_q;
        if (state_q == PH_PAUSED) score_inc = 1'b0;
`endif
        // Expires on the tick that brings the count to zero; a zero load exits on the first tick.
        delay_done = bus.FRAME_TICK && (cnt_q <= CNT_W'(1));

        case (state_q)
            PH_IDLE, PH_OVER: begin
                if (state_q == PH_OVER) armed_d = armed_q | ~bus.BTN_START;
                if (bus.BTN_START && (state_q == PH_IDLE || armed_q)) begin
                    state_d               = PH_SERVE;
                    lives_d               = 3'(START_LIVES);
                    level_d               = '0;
                    score_clr             = 1'b1;
                    pulse_d.blocks_reload = 1'b1;
                    pulse_d.ball_reset    = 1'b1;
                end
            end
            PH_SERVE: begin
                if (pause_rise) begin
`ifdef BREAKOUT_PAUSE_EN
                    state_d = PH_PAUSED;
                    ret_d   = PH_SERVE;
`endif
                end else if (bus.BTN_RELEASE) begin
                    state_d = PH_PLAY;
                end
            end
            PH_PLAY: begin
                if (pause_rise) begin
`ifdef BREAKOUT_PAUSE_EN
                    state_d = PH_PAUSED;
                    ret_d   = PH_PLAY;
`endif
                end else if (bus.ALL_CLEARED) begin
                    state_d = PH_CLEAR;
                    cnt_d   = CNT_W'(CLEAR_DELAY_FRAMES);
                end else if (bus.BALL_LOST) begin
                    state_d = PH_LOST;
                    lives_d = lives_q - 3'd1;
                    cnt_d   = CNT_W'(LOST_DELAY_FRAMES);
                end
            end
            PH_LOST: begin
                if (delay_done) begin
                    cnt_d = '0;
                    if (lives_q == 3'd0) begin
                        state_d = PH_OVER;
                        armed_d = 1'b0;
                    end else begin
                        state_d            = PH_SERVE;
                        pulse_d.ball_reset = 1'b1;
                    end
                end else if (bus.FRAME_TICK) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PH_CLEAR: begin
                if (delay_done) begin
                    cnt_d                 = '0;
                    state_d               = PH_SERVE;
                    level_d               = (level_q == 3'(MAX_LEVEL)) ? 3'd0 : level_q + 3'd1;
                    pulse_d.blocks_reload = 1'b1;
                    pulse_d.ball_reset    = 1'b1;
                end else if (bus.FRAME_TICK) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef BREAKOUT_PAUSE_EN
            PH_PAUSED: begin
                if (pause_rise) state_d = ret_q;
            end
`endif
            default: state_d = PH_IDLE;
        endcase

        // Requiring both current and next phase active drops ticks on entry to SERVE
        // and keeps updates out of LOST/CLEAR/PAUSED on the exit cycle.
        pulse_d.start_update = bus.FRAME_TICK && is_active(state_q) && is_active(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= PH_IDLE;
            lives_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
        end
    end

`ifdef BREAKOUT_PAUSE_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_pause_q <= 1'b0;
            ret_q       <= PH_SERVE;
        end else begin
            btn_pause_q <= bus.BTN_PAUSE;
            ret_q       <= ret_d;
        end
    end
`endif

    bcd_score_counter u_score (
        .clk       (CLK),
        .rst       (RESET),
        .clr       (score_clr),
        .inc       (score_inc),
        .score_bcd (bus.SCORE_BCD)
    );

    assign bus.START_UPDATE  = pulse_q.start_update;
    assign bus.BALL_RESET    = pulse_q.ball_reset;
    assign bus.BLOCKS_RELOAD = pulse_q.blocks_reload;
    assign bus.RELEASE_OUT   = (state_q == PH_SERVE) & bus.BTN_RELEASE;
    assign bus.LIVES         = lives_q;
    assign bus.LEVEL         = level_q;
    assign bus.PHASE         = state_q;

endmodule

// File: tb/tb_breakout_session_controller.sv
// Bench for breakout_session_controller: expected pulse cycles are queued as
// stimulus is driven and popped by a negedge monitor; levels checked directly.
module tb_breakout_session_controller;
    import breakout_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    breakout_session_controller_if bus();

    breakout_session_controller dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int nc    = 0;
    int su_q[$];
    int br_q[$];
    int bl_q[$];
    int exp_score = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: every pulse must match the head of its queue; an overdue head is a miss.
    always @(negedge CLK) begin
        nc = nc + 1;
        if (su_q.size() > 0 && su_q[0] < nc) chk("su_missing", nc, su_q.pop_front());
        if (br_q.size() > 0 && br_q[0] < nc) chk("br_missing", nc, br_q.pop_front());
        if (bl_q.size() > 0 && bl_q[0] < nc) chk("bl_missing", nc, bl_q.pop_front());
        if (bus.START_UPDATE === 1'b1) begin
            if (su_q.size() == 0) chk("su_spurious", 1, 0);
            else                  chk("su_cycle", nc, su_q.pop_front());
        end
        if (bus.BALL_RESET === 1'b1) begin
            if (br_q.size() == 0) chk("br_spurious", 1, 0);
            else                  chk("br_cycle", nc, br_q.pop_front());
        end
        if (bus.BLOCKS_RELOAD === 1'b1) begin
            if (bl_q.size() == 0) chk("bl_spurious", 1, 0);
            else                  chk("bl_cycle", nc, bl_q.pop_front());
        end
    end

    task automatic cyc1();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_pulses(input bit br, input bit bl);
        if (br) br_q.push_back(nc + 2);
        if (bl) bl_q.push_back(nc + 2);
    endtask

    task automatic tick(input bit upd);
        bus.FRAME_TICK = 1'b1;
        if (upd) su_q.push_back(nc + 2);
        cyc1();
        bus.FRAME_TICK = 1'b0;
        cyc1();
        cyc1();
    endtask

    task automatic new_game();
        bus.BTN_START = 1'b1;
        expect_pulses(1, 1);
        cyc1();
        bus.BTN_START = 1'b0;
        exp_score = 0;
        chk("ng_phase", bus.PHASE, PH_SERVE);
        chk("ng_lives", bus.LIVES, 3);
        chk("ng_level", bus.LEVEL, 0);
        chk("ng_score", bus.SCORE_BCD, 0);
    endtask

    task automatic serve();
        bus.BTN_RELEASE = 1'b1;
        #1;
        chk("release_out_serve", bus.RELEASE_OUT, 1);
        cyc1();
        chk("serve_phase", bus.PHASE, PH_PLAY);
        chk("release_out_play", bus.RELEASE_OUT, 0);
        bus.BTN_RELEASE = 1'b0;
    endtask

    task automatic wait_delay(input int n, input bit br, input bit bl);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) expect_pulses(br, bl);
            tick(0);
        end
    endtask

    task automatic lose(input int exp_lives, input bit hit);
        bus.BALL_LOST = 1'b1;
        bus.BLOCK_HIT = hit;
        cyc1();
        bus.BALL_LOST = 1'b0;
        bus.BLOCK_HIT = 1'b0;
        if (hit) exp_score++;
        chk("lost_lives", bus.LIVES, exp_lives);
        chk("lost_phase", bus.PHASE, PH_LOST);
        chk("lost_score", bus.SCORE_BCD, to_bcd(exp_score));
        wait_delay(60, exp_lives != 0, 0);
        chk("lost_exit_phase", bus.PHASE, (exp_lives == 0) ? PH_OVER : PH_SERVE);
    endtask

    task automatic clear(input int exp_level);
        bus.ALL_CLEARED = 1'b1;
        bus.BALL_LOST   = 1'b1;
        cyc1();
        bus.ALL_CLEARED = 1'b0;
        bus.BALL_LOST   = 1'b0;
        chk("clear_phase", bus.PHASE, PH_CLEAR);
        chk("clear_lives", bus.LIVES, 3);
        wait_delay(90, 1, 1);
        chk("clear_level", bus.LEVEL, exp_level);
        chk("clear_exit_phase", bus.PHASE, PH_SERVE);
    endtask

    task automatic hits(input int n);
        bus.BLOCK_HIT = 1'b1;
        repeat (n) cyc1();
        bus.BLOCK_HIT = 1'b0;
        exp_score = (exp_score + n > 9999) ? 9999 : exp_score + n;
        chk("score", bus.SCORE_BCD, to_bcd(exp_score));
    endtask

    initial begin
        RESET           = 1'b1;
        bus.FRAME_TICK  = 1'b0;
        bus.BTN_START   = 1'b0;
        bus.BTN_RELEASE = 1'b0;
        bus.BALL_LOST   = 1'b0;
        bus.BLOCK_HIT   = 1'b0;
        bus.ALL_CLEARED = 1'b0;
`ifdef BREAKOUT_PAUSE_EN
        bus.BTN_PAUSE   = 1'b0;
`endif
        repeat (3) cyc1();
        RESET = 1'b0;
        cyc1();
        chk("rst_phase", bus.PHASE, PH_IDLE);
        chk("rst_lives", bus.LIVES, 0);
        chk("rst_level", bus.LEVEL, 0);
        chk("rst_score", bus.SCORE_BCD, 0);
        tick(0);
        tick(0);

        new_game();
        tick(1);
        tick(1);
        bus.BALL_LOST = 1'b1;
        cyc1();
        bus.BALL_LOST = 1'b0;
        chk("lost_in_serve_phase", bus.PHASE, PH_SERVE);
        chk("lost_in_serve_lives", bus.LIVES, 3);

        serve();
        tick(1);
        hits(3);
        lose(2, 1);
        tick(1);

        serve();
`ifdef BREAKOUT_PAUSE_EN
        bus.BTN_PAUSE = 1'b1;
        cyc1();
        chk("pause_phase", bus.PHASE, PH_PAUSED);
        bus.BTN_PAUSE = 1'b0;
        tick(0);
        bus.BALL_LOST = 1'b1;
        bus.BLOCK_HIT = 1'b1;
        cyc1();
        bus.BALL_LOST = 1'b0;
        bus.BLOCK_HIT = 1'b0;
        chk("pause_lost_phase", bus.PHASE, PH_PAUSED);
        chk("pause_lost_lives", bus.LIVES, 2);
        chk("pause_hit_score", bus.SCORE_BCD, to_bcd(exp_score));
        bus.BTN_PAUSE = 1'b1;
        cyc1();
        bus.BTN_PAUSE = 1'b0;
        chk("resume_phase", bus.PHASE, PH_PLAY);
        tick(1);
`endif
        lose(1, 0);
        serve();
        bus.BTN_START = 1'b1;
        lose(0, 0);
        repeat (4) cyc1();
        chk("over_held_phase", bus.PHASE, PH_OVER);
        tick(0);
        bus.BTN_START = 1'b0;
        cyc1();
        chk("over_released_phase", bus.PHASE, PH_OVER);
        new_game();

        hits(99);
        hits(1);
        chk("score_0100", bus.SCORE_BCD, 16'h0100);
        hits(9898);
        hits(1);
        chk("score_9999", bus.SCORE_BCD, 16'h9999);
        hits(1);

        for (int l = 1; l <= 8; l++) begin
            serve();
            clear(l % 8);
            tick(1);
        end

        serve();
        RESET = 1'b1;
        cyc1();
        RESET = 1'b0;
        chk("midrst_phase", bus.PHASE, PH_IDLE);
        chk("midrst_lives", bus.LIVES, 0);
        chk("midrst_level", bus.LEVEL, 0);
        chk("midrst_score", bus.SCORE_BCD, 0);
        repeat (3) cyc1();

        chk("su_q_empty", su_q.size(), 0);
        chk("br_q_empty", br_q.size(), 0);
        chk("bl_q_empty", bl_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
